cdec8_mem_responder: RTL and testbench
======================================

// Module: cdec8_mem_responder
// PURPOSE
//  Bus responder for the CDEC8 core's memory port: 256x8 main memory, two memory-mapped I/O
//  registers (LED out, switch in) and a byte-stream program loader.
//  Holds the core in reset while a program is streamed in, then releases it.
//  Second read-only port (mon_*) gives the board monitor a view of memory without disturbing the core.
// PARAMETERS
//  IO_LED_ADRS     8'hFF  CPU address of LED output register (R/W)
//  IO_SW_ADRS      8'hFE  CPU address of switch input (read-only; CPU writes ignored)
//  AUTO_RUN        0      1: release core right after reset (memory preloaded); 0: wait for a load
//  SW_SYNC_STAGES  2      flip-flop stages on sw_in (>=2)
// PORTS
//  clock        in   1  system clock; all state updates on rising edge
//  reset_N      in   1  asynchronous active-low reset
//  adrs         in   8  CPU address
//  data_out     in   8  CPU write data
//  mmwr_en      in   1  CPU write strobe, high for one cycle per write
//  data_in      out  8  read data to CPU
//  cpu_reset_N  out  1  reset to core, active low
//  ld_start     in   1  pulse: begin a load (accepted in any state)
//  ld_valid     in   1  loader byte valid
//  ld_data      in   8  loader byte
//  ld_last      in   1  qualifies the final byte of a load
//  ld_ready     out  1  responder accepts a loader byte this cycle
//  ld_done      out  1  one-cycle pulse when a load completes
//  sw_in        in   8  board switches, asynchronous
//  led_out      out  8  LED register
//  mon_adrs     in   8  monitor read address
//  mon_data     out  8  memory[mon_adrs], combinational, memory array only (no I/O overlay)
// BEHAVIOUR
//  Reset values: cpu_reset_N=0, ld_ready=0, ld_done=0, led_out=0, sync regs=0, load ptr=0.
//   FSM -> RELEASE if AUTO_RUN=1, else HOLD. Memory contents are not reset.
//  CPU read: data_in combinational, no wait states.
//   adrs==IO_LED_ADRS -> led_out; adrs==IO_SW_ADRS -> synced switches; else mem[adrs].
//  CPU write: on an edge with mmwr_en=1 and state RUN.
//   IO_LED_ADRS -> led_out<=data_out.
//   IO_SW_ADRS  -> ignored.
//   Otherwise   -> mem[adrs]<=data_out.
//   I/O addresses never write the array.
//   Written value is readable in the next cycle.
//   mmwr_en outside RUN is ignored.
//  Switch path: SW_SYNC_STAGES-deep synchronizer; CPU sees a sw_in change after SW_SYNC_STAGES edges.
//  FSM states:
//   HOLD     cpu_reset_N=0, ld_ready=0. ld_start -> LOAD.
//   LOAD     cpu_reset_N=0, ld_ready=1.
//             Each edge with ld_valid=1: mem[ptr]<=ld_data, ptr<=ptr+1 (8-bit wrap).
//             Loader writes the array at all 256 addresses, including the two I/O addresses.
//             Accepted byte with ld_last=1 -> RELEASE, ld_done=1 in the next cycle.
//             More than 256 bytes without ld_last wraps and overwrites from 0.
//   RELEASE  cpu_reset_N=0 for exactly one cycle, ld_ready=0 -> RUN.
//   RUN      cpu_reset_N=1. ld_start -> LOAD, cpu_reset_N=0 from the next cycle.
//  ld_start is accepted in every state, including LOAD and RELEASE, and restarts the load.
//   It sets ptr<=0 and goes to LOAD.
//   ld_start and ld_valid on the same edge: ld_start wins and the byte is dropped.
//  ld_done pulses exactly once per completed load; it does not pulse for AUTO_RUN.
//  led_out holds its value across loads; only reset_N clears it.
//  Asserting reset_N mid-load aborts the load: the partial image stays in memory, FSM returns to its reset state.
// TESTING
//  Reset (AUTO_RUN=0): cpu_reset_N=0, led_out=00, ld_ready=0.
//   ld_start, then bytes 3E,01,FF with ld_last on FF.
//   -> mem[0..2]=3E,01,FF, ld_done pulses once, cpu_reset_N rises 2 cycles after FF is accepted.
//  RUN: CPU writes A5 to 0x10.
//   -> next cycle adrs=10 reads A5, mon_adrs=10 gives A5.
//  RUN: CPU writes 5A to 0xFF.
//   -> led_out=5A, mem[FF] unchanged via mon.
//   Then write to 0xFE -> memory and LEDs unchanged.
//  sw_in 00->C3 with adrs=FE -> data_in=00 for the first SW_SYNC_STAGES-1 edges, C3 after SW_SYNC_STAGES edges.
//  Load 257 bytes (k=0..256, byte=k[7:0]), ld_last on the last byte.
//   -> mem[0]=00, because the wrapped byte 256 is 00 and overwrites mem[0].
//   ld_start in RUN -> cpu_reset_N=0 next cycle.
//   reset_N asserted mid-load -> back to HOLD, ld_done not pulsed.

Source files
------------

// File: rtl/cdec8_mem_responder.sv
// cdec8_mem_responder: memory-port responder for the CDEC8 core.
// Provides a 256x8 main memory, an LED output register, a synchronised switch
// input and a byte-stream program loader that holds the core in reset while a
// program image is streamed in. A second read-only port lets the board monitor
// inspect the array without touching the core's port.
module cdec8_mem_responder #(
  parameter logic [7:0] IO_LED_ADRS    = 8'hFF,
  parameter logic [7:0] IO_SW_ADRS     = 8'hFE,
  parameter int         AUTO_RUN       = 0,
  parameter int         SW_SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic [7:0] adrs,
  input  logic [7:0] data_out,
  input  logic       mmwr_en,
  output logic [7:0] data_in,
  output logic       cpu_reset_N,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       ld_done,
  input  logic [7:0] sw_in,
  output logic [7:0] led_out,
  input  logic [7:0] mon_adrs,
  output logic [7:0] mon_data
);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  // With a preloaded memory the core goes straight through the one-cycle release.
  localparam state_t RST_STATE = (AUTO_RUN != 0) ? ST_RELEASE : ST_HOLD;

  state_t     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] led_q, led_d;
  logic       done_q, done_d;
  logic       cpu_rst_n_q;
  logic       ld_ready_q;
  logic [SW_SYNC_STAGES-1:0][7:0] sw_sync_q;
  logic [7:0] mem_q [0:255];

  logic       mem_we_s;
  logic [7:0] mem_wa_s;
  logic [7:0] mem_wd_s;

  // Next-state logic for the loader FSM plus the shared array write port.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    led_d    = led_q;
    done_d   = 1'b0;
    mem_we_s = 1'b0;
    mem_wa_s = adrs;
    mem_wd_s = data_out;

    if (ld_start) begin
      // A start pulse always restarts the load; a coincident loader byte is dropped.
      state_d = ST_LOAD;
      ptr_d   = 8'h00;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_d = ST_HOLD;
        end
        ST_LOAD: begin
          if (ld_valid) begin
            // Loader writes every address, I/O addresses included.
            mem_we_s = 1'b1;
            mem_wa_s = ptr_q;
            mem_wd_s = ld_data;
            ptr_d    = ptr_q + 8'd1;
            if (ld_last) begin
              state_d = ST_RELEASE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_RELEASE: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end

    // CPU writes only take effect while the core is running. The loader port is
    // only active in LOAD, so the two writers never collide.
    if ((state_q == ST_RUN) && mmwr_en) begin
      if (adrs == IO_LED_ADRS) begin
        led_d = data_out;
      end else if (adrs == IO_SW_ADRS) begin
        led_d = led_q;
      end else begin
        mem_we_s = 1'b1;
        mem_wa_s = adrs;
        mem_wd_s = data_out;
      end
    end else begin
      led_d = led_d;
    end
  end

  // State, pointer, LED register and registered handshake outputs.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_q     <= RST_STATE;
      ptr_q       <= 8'h00;
      led_q       <= 8'h00;
      done_q      <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      ld_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      led_q       <= led_d;
      done_q      <= done_d;
      cpu_rst_n_q <= (state_d == ST_RUN);
      ld_ready_q  <= (state_d == ST_LOAD);
    end
  end

  // Multi-stage synchroniser for the asynchronous board switches.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      sw_sync_q <= '0;
    end else begin
      sw_sync_q <= {sw_sync_q[SW_SYNC_STAGES-2:0], sw_in};
    end
  end

  // Main memory array; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_q[mem_wa_s] <= mem_wd_s;
    end
  end

  // Zero-wait-state CPU read mux with the I/O overlay.
  always_comb begin
    data_in = mem_q[adrs];
    if (adrs == IO_LED_ADRS) begin
      data_in = led_q;
    end else if (adrs == IO_SW_ADRS) begin
      data_in = sw_sync_q[SW_SYNC_STAGES-1];
    end else begin
      data_in = mem_q[adrs];
    end
  end

  assign mon_data    = mem_q[mon_adrs];
  assign cpu_reset_N = cpu_rst_n_q;
  assign ld_ready    = ld_ready_q;
  assign ld_done     = done_q;
  assign led_out     = led_q;

endmodule

// File: tb/tb_cdec8_mem_responder.sv
// Scoreboard bench for cdec8_mem_responder (default parameters, AUTO_RUN=0).
module tb_cdec8_mem_responder;

  logic       clock = 1'b0;
  logic       reset_N;
  logic [7:0] adrs, data_out, data_in, ld_data, sw_in, led_out, mon_adrs, mon_data;
  logic       mmwr_en, cpu_reset_N, ld_start, ld_valid, ld_last, ld_ready, ld_done;

  cdec8_mem_responder dut (
    .clock(clock), .reset_N(reset_N), .adrs(adrs), .data_out(data_out),
    .mmwr_en(mmwr_en), .data_in(data_in), .cpu_reset_N(cpu_reset_N),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_done(ld_done),
    .sw_in(sw_in), .led_out(led_out), .mon_adrs(mon_adrs), .mon_data(mon_data)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] load_q [$];
  logic [7:0] mem_m [256];

  // Count every cycle in which the load-complete pulse is high.
  always @(posedge clock) if (ld_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mon_check(input string tag, input logic [7:0] a);
    exp_q.push_back(mem_m[a]);
    mon_adrs = a;
    #1;
    chk(tag, mon_data, exp_q.pop_front());
  endtask

  task automatic cpu_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    exp_q.push_back(exp);
    adrs = a;
    #1;
    chk(tag, data_in, exp_q.pop_front());
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    adrs = a; data_out = d; mmwr_en = 1'b1;
    tick();
    mmwr_en = 1'b0;
  endtask

  // Stream load_q through the loader and check the completion handshake.
  task automatic do_load(input string tag);
    int base;
    logic [7:0] p;
    base = done_cnt;
    p = 8'h00;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk({tag, "_ready"}, {7'd0, ld_ready}, 8'd1);
    chk({tag, "_cpurst_load"}, {7'd0, cpu_reset_N}, 8'd0);
    for (int i = 0; i < load_q.size(); i++) begin
      ld_valid = 1'b1;
      ld_data  = load_q[i];
      ld_last  = (i == load_q.size() - 1);
      mem_m[p] = load_q[i];
      p = p + 8'd1;
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk({tag, "_done_pulse"}, {7'd0, ld_done}, 8'd1);
    chk({tag, "_cpurst_release"}, {7'd0, cpu_reset_N}, 8'd0);
    tick();
    chk({tag, "_cpurst_run"}, {7'd0, cpu_reset_N}, 8'd1);
    chk({tag, "_done_low"}, {7'd0, ld_done}, 8'd0);
    tick();
    chk({tag, "_done_once"}, 8'(done_cnt - base), 8'd1);
  endtask

  initial begin
    reset_N = 1'b0; adrs = 8'h00; data_out = 8'h00; mmwr_en = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    sw_in = 8'h00; mon_adrs = 8'h00;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_cpurst", {7'd0, cpu_reset_N}, 8'd0);
    chk("rst_led", led_out, 8'h00);
    chk("rst_ready", {7'd0, ld_ready}, 8'd0);
    chk("rst_done", {7'd0, ld_done}, 8'd0);
    reset_N = 1'b1;
    tick();
    chk("hold_cpurst", {7'd0, cpu_reset_N}, 8'd0);
    chk("hold_ready", {7'd0, ld_ready}, 8'd0);

    // CPU write outside RUN must be ignored.
    cpu_write(8'hFF, 8'h99);
    chk("hold_wr_led", led_out, 8'h00);

    // Small program load.
    load_q = {8'h3E, 8'h01, 8'hFF};
    do_load("ld3");
    mon_check("ld3_m0", 8'h00);
    mon_check("ld3_m1", 8'h01);
    mon_check("ld3_m2", 8'h02);

    // 257-byte load wraps and overwrites address 0; I/O addresses are loaded too.
    load_q.delete();
    for (int k = 0; k <= 256; k++) load_q.push_back(8'(k));
    do_load("ld257");
    mon_check("wrap_m0", 8'h00);
    mon_check("wrap_m1", 8'h01);
    mon_check("wrap_m80", 8'h80);
    mon_check("wrap_mFE", 8'hFE);
    mon_check("wrap_mFF", 8'hFF);

    // CPU write to ordinary memory.
    cpu_write(8'h10, 8'hA5);
    mem_m[8'h10] = 8'hA5;
    cpu_read("rd10", 8'h10, 8'hA5);
    mon_check("mon10", 8'h10);

    // CPU write to LED register leaves the array alone.
    cpu_write(8'hFF, 8'h5A);
    chk("led_5a", led_out, 8'h5A);
    mon_check("monFF_keep", 8'hFF);
    cpu_read("rdFF_led", 8'hFF, 8'h5A);

    // CPU write to switch address is ignored.
    cpu_write(8'hFE, 8'h77);
    chk("led_keep", led_out, 8'h5A);
    mon_check("monFE_keep", 8'hFE);
    cpu_read("rdFE_sw0", 8'hFE, 8'h00);

    // Switch synchroniser latency.
    adrs = 8'hFE;
    sw_in = 8'hC3;
    tick();
    cpu_read("sw_edge1", 8'hFE, 8'h00);
    tick();
    cpu_read("sw_edge2", 8'hFE, 8'hC3);

    // ld_start in RUN with a coincident byte: byte dropped, core reset next cycle.
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'hEE;
    tick();
    ld_start = 1'b0;
    chk("restart_cpurst", {7'd0, cpu_reset_N}, 8'd0);
    chk("restart_ready", {7'd0, ld_ready}, 8'd1);
    chk("restart_led", led_out, 8'h5A);
    ld_data = 8'hAA; mem_m[8'h00] = 8'hAA;
    tick();
    ld_data = 8'hBB; mem_m[8'h01] = 8'hBB;
    tick();
    ld_valid = 1'b0;

    // Reset mid-load aborts: partial image stays, back to HOLD, no done pulse.
    begin
      int base;
      base = done_cnt;
      reset_N = 1'b0;
      #1;
      chk("abort_cpurst", {7'd0, cpu_reset_N}, 8'd0);
      chk("abort_ready", {7'd0, ld_ready}, 8'd0);
      chk("abort_led", led_out, 8'h00);
      reset_N = 1'b1;
      tick();
      tick();
      chk("abort_hold_cpurst", {7'd0, cpu_reset_N}, 8'd0);
      chk("abort_hold_ready", {7'd0, ld_ready}, 8'd0);
      chk("abort_no_done", 8'(done_cnt - base), 8'd0);
    end
    mon_check("partial_m0", 8'h00);
    mon_check("partial_m1", 8'h01);
    mon_check("partial_m2", 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
